calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Command sequencer for the 32-entry stack/queue Memory block of the calculator.
- Accepts one calculator command at a time: push operand, binary ALU operation, or clear.
- Drives the Memory push/pop/stackQueue/dataIn pins and tracks occupancy locally.
- Reports a result word and error code per command; sits between the user-input front end and Memory.

Parameters:
- DEPTH, 32, Memory entry count; sets the overflow bound.
- CNT_W, 6, occupancy counter width; must hold 0..DEPTH.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset (integrator drives Memory rst with ~rst).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&cmd_ready.
- cmd_op  in  3  000 PUSH, 001 ADD, 010 SUB, 011 MUL, 100 AND, 101 OR, 110 XOR, 111 CLEAR.
- cmd_mode  in  1  0 stack (LIFO operands), 1 queue (FIFO operands).
- cmd_data  in  32  operand for PUSH; ignored otherwise.
- mem_push  out  1  to Memory push.
- mem_pop  out  1  to Memory pop.
- mem_stackQueue  out  1  to Memory stackQueue.
- mem_dataIn  out  32  to Memory dataIn.
- mem_stackOut  in  32  from Memory stackOut.
- mem_queueOut  in  32  from Memory queueOut.
- mem_empty  in  1  from Memory empty.
- mem_full  in  1  from Memory full.
- res_valid  out  1  one-cycle pulse at command completion.
- res_data  out  32  result / pushed value / cleared count; held until next res_valid.
- res_err  out  2  00 ok, 01 underflow, 10 overflow; valid with res_valid.
- depth  out  CNT_W  local occupancy count.

Behaviour:
- Reset, synchronous: state=IDLE, depth=0, cmd_ready=1, and all mem_* outputs, res_valid, res_data and res_err = 0.
- Reset mid-command aborts it; no further push or pop is issued.
- Opcode and mode are latched at accept.
- mem_stackQueue = latched mode during POP_A and POP_B, 0 otherwise.
- mem_push and mem_pop are never high together.
- States: IDLE, POP_A, POP_B, EXEC, PUSH_R, CLR, DONE.
- IDLE, on accept:
  - PUSH with depth==DEPTH or mem_full: -> DONE, err=10.
  - PUSH otherwise: -> PUSH_R with operand=cmd_data.
  - Binary op with depth<2: -> DONE, err=01, Memory untouched.
  - Binary op otherwise: -> POP_A.
  - CLEAR: -> CLR.
- POP_A: mem_pop=1; X <= stackOut (stack mode) or queueOut (queue mode); -> POP_B.
- POP_B: mem_pop=1; Y <= same selection; -> EXEC.
- EXEC: operand order gives L=Y, R=X in stack mode and L=X, R=Y in queue mode. Result = L op R. ADD, SUB and MUL keep the low 32 bits (wrap). Result is registered; -> PUSH_R.
- PUSH_R: mem_push=1, mem_dataIn=result or operand; -> DONE.
- CLR: mem_pop=1 each cycle while depth!=0, counting pops. At depth==0 (including 0 on entry) -> DONE with res_data=count.
- DONE: res_valid=1; -> IDLE.
- depth: +1 in the cycle after mem_push, -1 in the cycle after each mem_pop. A binary op nets -1.
- Latency from accept edge to the res_valid cycle: PUSH 2, binary op 5, error 1, CLEAR n+1.
- A mismatch between mem_empty and depth==0 in IDLE is a sticky internal error visible only to assertions; behaviour still follows depth.

Optional Feature:
- CALC_SAT_EN defined: ADD and SUB use signed saturation, clamping to 0x7FFFFFFF or 0x80000000 on signed overflow. res_err=11 marks a saturated but completed result.
- CALC_SAT_EN undefined: ADD and SUB wrap modulo 2^32; code 11 is never produced.

Test Plan:
- Stack mode: PUSH 5, PUSH 3, SUB -> res 2, err 00, depth 1, Memory stackOut=2; ADD latency exactly 5 cycles.
- Queue mode: PUSH 5, PUSH 3, SUB -> res 2, depth 1. Then PUSH 10, SUB -> operands 2,10, res 0xFFFFFFF8.
- Empty: ADD -> err 01, no mem_pop pulse. PUSH 7 then MUL -> err 01, depth stays 1.
- 32 PUSHes of 1..32 -> depth 32, mem_full=1; 33rd PUSH -> err 10, no mem_push. MUL in stack mode -> res 32*31=992.
- PUSH 4 values, CLEAR -> exactly 4 mem_pop cycles, res_data 4, depth 0, mem_empty=1. CLEAR again -> res_data 0.
- rst asserted during POP_B -> next cycle IDLE, depth 0, outputs 0. With CALC_SAT_EN: 0x7FFFFFFF ADD 1 -> 0x7FFFFFFF, err 11.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: command sequencer in front of the calculator's 32-entry
// stack/queue Memory block. Takes one command at a time (PUSH, binary ALU
// op, CLEAR), drives the Memory push/pop pins, tracks occupancy locally
// and reports a result word plus error code per command.
// Optional build macro: CALC_SAT_EN enables signed saturation on ADD/SUB
// (res_err=11 flags a saturated result); without it ADD/SUB wrap.
//
// Handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so exactly one
// command is in flight and the next is accepted after the res_valid pulse.
module calc_sequencer #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic [31:0]      cmd_data,
  output logic             mem_push,
  output logic             mem_pop,
  output logic             mem_stackQueue,
  output logic [31:0]      mem_dataIn,
  input  logic [31:0]      mem_stackOut,
  input  logic [31:0]      mem_queueOut,
  input  logic             mem_empty,
  input  logic             mem_full,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [1:0]       res_err,
  output logic [CNT_W-1:0] depth
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP_A  = 3'd1;
  localparam logic [2:0] S_POP_B  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_PUSH_R = 3'd4;
  localparam logic [2:0] S_CLR    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic [2:0]       state;
  logic [2:0]       op_q;
  logic             mode_q;
  logic [31:0]      x_q;
  logic [31:0]      y_q;
  logic [31:0]      acc_q;     // operand to push, or registered ALU result
  logic             sat_q;
  logic [CNT_W-1:0] clr_cnt;
  logic [CNT_W-1:0] clr_next;
  logic             sync_err;  // sticky: mem_empty disagreed with depth in IDLE

  logic [31:0] pop_data;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_res;
  logic        alu_sat;

  assign cmd_ready      = (state == S_IDLE);
  assign mem_push       = (state == S_PUSH_R);
  assign mem_pop        = (state == S_POP_A) || (state == S_POP_B) ||
                          ((state == S_CLR) && (depth != '0));
  assign mem_stackQueue = ((state == S_POP_A) || (state == S_POP_B)) ? mode_q : 1'b0;
  assign mem_dataIn     = mem_push ? acc_q : 32'd0;
  assign res_valid      = (state == S_DONE);
  assign pop_data       = mode_q ? mem_queueOut : mem_stackOut;
  assign clr_next       = clr_cnt + CNT_W'(1);

  // ALU: stack mode pops the right operand first, queue mode the left one.
  always_comb begin
    lhs     = mode_q ? x_q : y_q;
    rhs     = mode_q ? y_q : x_q;
    sum     = lhs + rhs;
    diff    = lhs - rhs;
    alu_res = 32'd0;
    alu_sat = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum;
`ifdef CALC_SAT_EN
        if ((lhs[31] == rhs[31]) && (sum[31] != lhs[31])) begin
          alu_sat = 1'b1;
          alu_res = lhs[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
      end
      OP_SUB: begin
        alu_res = diff;
`ifdef CALC_SAT_EN
        if ((lhs[31] != rhs[31]) && (diff[31] != lhs[31])) begin
          alu_sat = 1'b1;
          alu_res = lhs[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
      end
      OP_MUL:  alu_res = lhs * rhs;
      OP_AND:  alu_res = lhs & rhs;
      OP_OR:   alu_res = lhs | rhs;
      OP_XOR:  alu_res = lhs ^ rhs;
      default: alu_res = 32'd0;
    endcase
  end

  // Command FSM and its datapath registers; results land as DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_PUSH;
      mode_q   <= 1'b0;
      x_q      <= 32'd0;
      y_q      <= 32'd0;
      acc_q    <= 32'd0;
      sat_q    <= 1'b0;
      clr_cnt  <= '0;
      res_data <= 32'd0;
      res_err  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            mode_q  <= cmd_mode;
            sat_q   <= 1'b0;
            clr_cnt <= '0;
            if (cmd_op == OP_PUSH) begin
              if ((depth == CNT_W'(DEPTH)) || mem_full) begin
                res_data <= 32'd0;
                res_err  <= 2'b10;
                state    <= S_DONE;
              end else begin
                acc_q <= cmd_data;
                state <= S_PUSH_R;
              end
            end else if (cmd_op == OP_CLEAR) begin
              state <= S_CLR;
            end else if (depth < CNT_W'(2)) begin
              res_data <= 32'd0;
              res_err  <= 2'b01;
              state    <= S_DONE;
            end else begin
              state <= S_POP_A;
            end
          end
        end
        S_POP_A: begin
          x_q   <= pop_data;
          state <= S_POP_B;
        end
        S_POP_B: begin
          y_q   <= pop_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          acc_q <= alu_res;
          sat_q <= alu_sat;
          state <= S_PUSH_R;
        end
        S_PUSH_R: begin
          res_data <= acc_q;
          res_err  <= sat_q ? 2'b11 : 2'b00;
          state    <= S_DONE;
        end
        S_CLR: begin
          // Leave on the last pop so CLEAR of n entries completes in n+1.
          if (depth == '0) begin
            res_data <= 32'(clr_cnt);
            res_err  <= 2'b00;
            state    <= S_DONE;
          end else begin
            clr_cnt <= clr_next;
            if (depth == CNT_W'(1)) begin
              res_data <= 32'(clr_next);
              res_err  <= 2'b00;
              state    <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Occupancy follows the pins driven to Memory, one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (mem_push) begin
      depth <= depth + CNT_W'(1);
    end else if (mem_pop) begin
      depth <= depth - CNT_W'(1);
    end
  end

  // Sticky flag for Memory empty disagreeing with local occupancy in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else if ((state == S_IDLE) && (mem_empty != (depth == '0))) begin
      sync_err <= 1'b1;
    end
  end

  sync_err_never: assert property (@(posedge clk) disable iff (rst) !sync_err);

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench for calc_sequencer with a behavioural
// stack/queue Memory model, a driver task, and a scoreboard/monitor that
// checks result, error code, occupancy and latency of every command.
module tb_calc_sequencer;

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_mode;
  logic [31:0] cmd_data;
  logic        mem_push;
  logic        mem_pop;
  logic        mem_stackQueue;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_stackOut;
  logic [31:0] mem_queueOut;
  logic        mem_empty;
  logic        mem_full;
  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_err;
  logic [5:0]  depth;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  // scoreboard entry: {latency[7:0], depth[5:0], err[1:0], data[31:0]}
  logic [47:0] exp_q[$];
  int          acc_cyc_q[$];

  calc_sequencer #(.DEPTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .mem_push(mem_push), .mem_pop(mem_pop), .mem_stackQueue(mem_stackQueue),
    .mem_dataIn(mem_dataIn), .mem_stackOut(mem_stackOut),
    .mem_queueOut(mem_queueOut), .mem_empty(mem_empty), .mem_full(mem_full),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .depth(depth)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_push) push_cnt <= push_cnt + 1;
    if (mem_pop)  pop_cnt  <= pop_cnt + 1;
  end

  // Memory model: circular buffer, push at tail, pop tail (stack) or head (queue)
  logic [31:0] mem [0:31];
  logic [4:0]  head;
  logic [5:0]  cnt;

  always @(posedge clk) begin
    if (rst) begin
      head <= 5'd0;
      cnt  <= 6'd0;
    end else if (mem_push && cnt != 6'd32) begin
      mem[head + cnt[4:0]] <= mem_dataIn;
      cnt <= cnt + 6'd1;
    end else if (mem_pop && cnt != 6'd0) begin
      if (mem_stackQueue) head <= head + 5'd1;
      cnt <= cnt - 6'd1;
    end
  end

  assign mem_stackOut = (cnt == 6'd0) ? 32'd0 : mem[head + cnt[4:0] - 5'd1];
  assign mem_queueOut = (cnt == 6'd0) ? 32'd0 : mem[head];
  assign mem_empty    = (cnt == 6'd0);
  assign mem_full     = (cnt == 6'd32);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pop and compare on every res_valid
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (exp_q.size() == 0 || acc_cyc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_res: res_data %h res_err %b with empty scoreboard", res_data, res_err);
      end else begin
        logic [47:0] e;
        int          a;
        e = exp_q.pop_front();
        a = acc_cyc_q.pop_front();
        chk("res_data", res_data, e[31:0]);
        chk("res_err", 32'(res_err), 32'(e[33:32]));
        chk("depth", 32'(depth), 32'(e[39:34]));
        chk("latency", 32'(cyc - a), 32'(e[47:40]));
      end
    end
  end

  // driver: issue one command, queue its expected response, wait for completion
  task automatic do_cmd(input logic [2:0] op, input logic mode, input logic [31:0] data,
                        input logic [31:0] ed, input logic [1:0] ee,
                        input logic [5:0] edep, input int lat);
    bit got;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mode  = mode;
    cmd_data  = data;
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.push_back({8'(lat), edep, ee, ed});
    @(posedge clk);
    #1;
    acc_cyc_q.push_back(cyc - 1);
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: op %b no res_valid within 100 cycles", op);
    end
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_mode = 1'b0;
    cmd_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_mem_pins", {28'd0, mem_push, mem_pop, mem_stackQueue, res_err != 2'b00}, 32'd0);
    chk("rst_dataIn", mem_dataIn, 32'd0);
    rst = 1'b0;

    // stack mode: 5 - 3 = 2, then ADD latency
    do_cmd(OP_PUSH, 1'b0, 32'd5, 32'd5, 2'b00, 6'd1, 2);
    do_cmd(OP_PUSH, 1'b0, 32'd3, 32'd3, 2'b00, 6'd2, 2);
    do_cmd(OP_SUB,  1'b0, 32'd0, 32'd2, 2'b00, 6'd1, 5);
    chk("stack_top", mem_stackOut, 32'd2);
    do_cmd(OP_PUSH, 1'b0, 32'd4, 32'd4, 2'b00, 6'd2, 2);
    do_cmd(OP_ADD,  1'b0, 32'd0, 32'd6, 2'b00, 6'd1, 5);
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd1, 2'b00, 6'd0, 2);

    // queue mode: 5 - 3 = 2, then 2 - 10
    do_cmd(OP_PUSH, 1'b1, 32'd5, 32'd5, 2'b00, 6'd1, 2);
    do_cmd(OP_PUSH, 1'b1, 32'd3, 32'd3, 2'b00, 6'd2, 2);
    do_cmd(OP_SUB,  1'b1, 32'd0, 32'd2, 2'b00, 6'd1, 5);
    do_cmd(OP_PUSH, 1'b1, 32'd10, 32'd10, 2'b00, 6'd2, 2);
    do_cmd(OP_SUB,  1'b1, 32'd0, 32'hFFFF_FFF8, 2'b00, 6'd1, 5);
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd1, 2'b00, 6'd0, 2);

    // underflow: no pops issued
    p0 = pop_cnt;
    do_cmd(OP_ADD,  1'b0, 32'd0, 32'd0, 2'b01, 6'd0, 1);
    chk("uflow_no_pop", 32'(pop_cnt - p0), 32'd0);
    do_cmd(OP_PUSH, 1'b0, 32'd7, 32'd7, 2'b00, 6'd1, 2);
    p0 = pop_cnt;
    do_cmd(OP_MUL,  1'b0, 32'd0, 32'd0, 2'b01, 6'd1, 1);
    chk("uflow1_no_pop", 32'(pop_cnt - p0), 32'd0);
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd1, 2'b00, 6'd0, 2);

    // fill to 32, overflow, then MUL of top two
    for (int i = 1; i <= 32; i++)
      do_cmd(OP_PUSH, 1'b0, 32'(i), 32'(i), 2'b00, 6'(i), 2);
    chk("full_flag", 32'(mem_full), 32'd1);
    p0 = push_cnt;
    do_cmd(OP_PUSH, 1'b0, 32'd99, 32'd0, 2'b10, 6'd32, 1);
    chk("oflow_no_push", 32'(push_cnt - p0), 32'd0);
    do_cmd(OP_MUL,  1'b0, 32'd0, 32'd992, 2'b00, 6'd31, 5);
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd31, 2'b00, 6'd0, 32);

    // CLEAR of 4 entries, then CLEAR of empty
    for (int i = 1; i <= 4; i++)
      do_cmd(OP_PUSH, 1'b0, 32'(i * 11), 32'(i * 11), 2'b00, 6'(i), 2);
    p0 = pop_cnt;
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd4, 2'b00, 6'd0, 5);
    chk("clear_pops", 32'(pop_cnt - p0), 32'd4);
    chk("clear_empty", 32'(mem_empty), 32'd1);
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 2);

    // bitwise ops
    do_cmd(OP_PUSH, 1'b0, 32'h0000_FF0F, 32'h0000_FF0F, 2'b00, 6'd1, 2);
    do_cmd(OP_PUSH, 1'b0, 32'h00F0_F0FF, 32'h00F0_F0FF, 2'b00, 6'd2, 2);
    do_cmd(OP_AND,  1'b0, 32'd0, 32'h0000_F00F, 2'b00, 6'd1, 5);
    do_cmd(OP_PUSH, 1'b0, 32'h1234_5678, 32'h1234_5678, 2'b00, 6'd2, 2);
    do_cmd(OP_XOR,  1'b1, 32'd0, 32'h1234_A677, 2'b00, 6'd1, 5);
    do_cmd(OP_PUSH, 1'b0, 32'h8000_0001, 32'h8000_0001, 2'b00, 6'd2, 2);
    do_cmd(OP_OR,   1'b0, 32'd0, 32'h9234_A677, 2'b00, 6'd1, 5);
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd1, 2'b00, 6'd0, 2);

    // signed overflow on ADD and SUB
    do_cmd(OP_PUSH, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00, 6'd1, 2);
    do_cmd(OP_PUSH, 1'b0, 32'd1, 32'd1, 2'b00, 6'd2, 2);
`ifdef CALC_SAT_EN
    do_cmd(OP_ADD,  1'b0, 32'd0, 32'h7FFF_FFFF, 2'b11, 6'd1, 5);
`else
    do_cmd(OP_ADD,  1'b0, 32'd0, 32'h8000_0000, 2'b00, 6'd1, 5);
`endif
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd1, 2'b00, 6'd0, 2);
    do_cmd(OP_PUSH, 1'b0, 32'h8000_0000, 32'h8000_0000, 2'b00, 6'd1, 2);
    do_cmd(OP_PUSH, 1'b0, 32'd1, 32'd1, 2'b00, 6'd2, 2);
`ifdef CALC_SAT_EN
    do_cmd(OP_SUB,  1'b0, 32'd0, 32'h8000_0000, 2'b11, 6'd1, 5);
`else
    do_cmd(OP_SUB,  1'b0, 32'd0, 32'h7FFF_FFFF, 2'b00, 6'd1, 5);
`endif
    do_cmd(OP_CLEAR, 1'b0, 32'd0, 32'd1, 2'b00, 6'd0, 2);

    // reset during POP_B aborts the command
    do_cmd(OP_PUSH, 1'b0, 32'd1, 32'd1, 2'b00, 6'd1, 2);
    do_cmd(OP_PUSH, 1'b0, 32'd2, 32'd2, 2'b00, 6'd2, 2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_SUB;
    cmd_mode  = 1'b0;
    @(posedge clk);   // accept -> POP_A
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);   // -> POP_B
    @(negedge clk);
    chk("popb_pop", 32'(mem_pop), 32'd1);
    rst = 1'b1;
    p0 = push_cnt;
    @(negedge clk);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_depth", 32'(depth), 32'd0);
    chk("abort_pins", {29'd0, mem_push, mem_pop, mem_stackQueue}, 32'd0);
    chk("abort_res", {res_data[29:0], res_err}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_push", 32'(push_cnt - p0), 32'd0);
    do_cmd(OP_PUSH, 1'b0, 32'd9, 32'd9, 2'b00, 6'd1, 2);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover: %0d expected responses never seen", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
